// File: rtl/mfp_ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings and helpers for the single-transfer master.
// Imported by the master top and its lane steering block.
package mfp_ahb_lite_master_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

   // Size code 3 is folded onto word.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'd3) ? 2'd2 : size;
   endfunction

   function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                             input logic [1:0]  size);
      case (size)
         2'd1:    return {addr[31:1], 1'b0};
         2'd2:    return {addr[31:2], 2'b00};
         default: return addr;
      endcase
   endfunction

endpackage

// File: rtl/mfp_ahb_lane_steer.sv
// Byte-lane steering: replicate narrow write data across the bus, or
// extract and zero-extend a narrow read from its lane.
module mfp_ahb_lane_steer
   import mfp_ahb_lite_master_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        extract,
   output logic [31:0] out
);

   logic [31:0] shifted;

   assign shifted = data >> {addr, 3'b000};

   always_comb begin
      out = data;
      if (extract) begin
         case ({1'b0, size})
            HSIZE_BYTE: out = {24'h0, shifted[7:0]};
            HSIZE_HALF: out = {16'h0, shifted[15:0]};
            default:    out = shifted;
         endcase
      end else begin
         case ({1'b0, size})
            HSIZE_BYTE: out = {4{data[7:0]}};
            HSIZE_HALF: out = {2{data[15:0]}};
            default:    out = data;
         endcase
      end
   end

endmodule

// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite single-transfer master: valid/ready commands in, pipelined
// NONSEQ/SINGLE transfers out, one in-order response per command.
module mfp_ahb_lite_master
   import mfp_ahb_lite_master_pkg::*;
#(
   parameter logic [3:0]  HPROT_VAL   = HPROT_DATA_PRIV,
   parameter logic [31:0] RESET_HADDR = 32'h0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [31:0] HADDR,
   output logic [2:0]  HBURST,
   output logic        HMASTLOCK,
   output logic [3:0]  HPROT,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   htrans_e     ap_trans;
   logic [1:0]  ap_size;
   logic [31:0] ap_wdata;
   logic        dp_valid;
   logic        dp_write;
   logic [1:0]  dp_addr;
   logic [1:0]  dp_size;
   logic        replay;
   logic        accept;
   logic        complete;
   logic [1:0]  size_n;
   logic [31:0] wdata_lanes;
   logic [31:0] rdata_lane;

   assign cmd_ready = HREADY && !replay && !HRESET;
   assign accept    = cmd_valid && cmd_ready;
   assign complete  = dp_valid && HREADY;
   assign size_n    = norm_size(cmd_size);

   assign HTRANS    = ap_trans;
   assign HSIZE     = {1'b0, ap_size};
   assign HBURST    = HBURST_SINGLE;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = HPROT_VAL;

   mfp_ahb_lane_steer u_wsteer (
      .data    (ap_wdata),
      .addr    (HADDR[1:0]),
      .size    (ap_size),
      .extract (1'b0),
      .out     (wdata_lanes)
   );

   mfp_ahb_lane_steer u_rsteer (
      .data    (HRDATA),
      .addr    (dp_addr),
      .size    (dp_size),
      .extract (1'b1),
      .out     (rdata_lane)
   );

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ap_trans  <= HTRANS_IDLE;
         HADDR     <= RESET_HADDR;
         HWRITE    <= 1'b0;
         ap_size   <= 2'd0;
         ap_wdata  <= 32'h0;
         HWDATA    <= 32'h0;
         dp_valid  <= 1'b0;
         dp_write  <= 1'b0;
         dp_addr   <= 2'd0;
         dp_size   <= 2'd0;
         replay    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_error <= 1'b0;
      end else begin
         rsp_valid <= complete;
         rsp_error <= complete && HRESP;
         rsp_rdata <= (complete && !dp_write) ? rdata_lane : 32'h0;
         if (HREADY) begin
            dp_valid <= (ap_trans == HTRANS_NONSEQ);
            dp_write <= HWRITE;
            dp_addr  <= HADDR[1:0];
            dp_size  <= ap_size;
            HWDATA   <= wdata_lanes;
            // A pending replay owns this edge; no new command enters.
            if (replay) begin
               ap_trans <= HTRANS_NONSEQ;
               replay   <= 1'b0;
            end else if (accept) begin
               ap_trans <= HTRANS_NONSEQ;
               HADDR    <= align_addr(cmd_addr, size_n);
               HWRITE   <= cmd_write;
               ap_size  <= size_n;
               ap_wdata <= cmd_wdata;
            end else begin
               ap_trans <= HTRANS_IDLE;
            end
         end else if (HRESP && ap_trans == HTRANS_NONSEQ) begin
            ap_trans <= HTRANS_IDLE;
            replay   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Directed bench for mfp_ahb_lite_master with a byte-memory AHB slave
// model (read-after-write stall, injectable waits and ERROR responses).
module tb_mfp_ahb_lite_master;

   localparam logic [31:0] RST_ADDR = 32'hA000_0000;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [1:0]  cmd_size;
   logic        rsp_valid, rsp_error;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [2:0]  HBURST, HSIZE;
   logic        HMASTLOCK, HWRITE, HREADY, HRESP;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic [31:0] d;
      logic        e;
   } rsp_t;
   rsp_t rq[$];

   logic [1:0]  tr_trans [4096];
   logic [31:0] tr_addr  [4096];
   logic [31:0] tr_wdata [4096];
   logic [2:0]  tr_size  [4096];
   logic        tr_write [4096];
   logic        tr_ready [4096];

   mfp_ahb_lite_master #(
      .HPROT_VAL   (4'b0011),
      .RESET_HADDR (RST_ADDR)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_write(cmd_write),
      .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error),
      .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
      .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS),
      .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   // ---------------- slave model ----------------
   logic [7:0] mem [64];
   logic       s_dv = 1'b0, s_dw = 1'b0;
   logic [5:0] s_da = 6'd0;
   logic [1:0] s_ds = 2'd0;
   logic [1:0] s_err = 2'd0;
   int         s_wait = 0;
   int         err_req = 0, err_ack = 0;
   int         wait_req = 0, wait_ack = 0, wait_len = 0;

   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (s_err == 2'd1) begin
         HREADY = 1'b0;
         HRESP  = 1'b1;
      end else if (s_err == 2'd2) begin
         HRESP = 1'b1;
      end else if (s_wait > 0) begin
         HREADY = 1'b0;
      end
      HRDATA = {mem[{s_da[5:2], 2'd3}], mem[{s_da[5:2], 2'd2}],
                mem[{s_da[5:2], 2'd1}], mem[{s_da[5:2], 2'd0}]};
   end

   always @(posedge HCLK) begin
      if (HRESET) begin
         s_dv   <= 1'b0;
         s_err  <= 2'd0;
         s_wait <= 0;
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
      end else if (HREADY) begin
         if (s_dv && s_dw && s_err == 2'd0) begin
            for (int b = 0; b < 4; b++) begin
               if (s_ds == 2'd2 || (s_ds == 2'd1 && b[1] == s_da[1]) ||
                   (s_ds == 2'd0 && b[1:0] == s_da[1:0]))
                  mem[{s_da[5:2], b[1:0]}] <= HWDATA[8*b +: 8];
            end
         end
         s_err  <= 2'd0;
         s_wait <= 0;
         if (HTRANS == 2'b10) begin
            s_dv <= 1'b1;
            s_dw <= HWRITE;
            s_da <= HADDR[5:0];
            s_ds <= HSIZE[1:0];
            if (HWRITE && err_req != err_ack) begin
               s_err   <= 2'd1;
               err_ack <= err_ack + 1;
            end else if (!HWRITE) begin
               if (wait_req != wait_ack) begin
                  wait_ack <= wait_ack + 1;
                  s_wait   <= wait_len + ((s_dv && s_dw) ? 1 : 0);
               end else begin
                  s_wait <= (s_dv && s_dw) ? 1 : 0;
               end
            end
         end else begin
            s_dv <= 1'b0;
         end
      end else begin
         if (s_err == 2'd1) s_err <= 2'd2;
         else if (s_wait > 0) s_wait <= s_wait - 1;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge HCLK) begin
      tr_trans[cyc[11:0]] = HTRANS;
      tr_addr[cyc[11:0]]  = HADDR;
      tr_wdata[cyc[11:0]] = HWDATA;
      tr_size[cyc[11:0]]  = HSIZE;
      tr_write[cyc[11:0]] = HWRITE;
      tr_ready[cyc[11:0]] = cmd_ready;
      if (rsp_valid) rq.push_back('{cyc, rsp_rdata, rsp_error});
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [31:0] a, input logic w,
                        input logic [1:0] s, input logic [31:0] d,
                        output int acc);
      @(negedge HCLK);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_write = w;
      cmd_size  = s;
      cmd_wdata = d;
      acc = -1;
      for (int i = 0; i < 40; i++) begin
         if (cmd_ready) begin
            acc = cyc;
            break;
         end
         @(negedge HCLK);
      end
      if (acc < 0) begin
         $display("FAIL issue_timeout addr %h never accepted", a);
         n_err++;
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
         $fatal(1, "command accept timeout");
      end
      @(posedge HCLK);
   endtask

   task automatic idle();
      @(negedge HCLK);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n);
      for (int i = 0; i < 40 && rq.size() < n; i++) @(negedge HCLK);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      HRESET = 1'b1;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
      cmd_size = 2'd0; cmd_wdata = '0;
      repeat (3) @(negedge HCLK);
      n_vec++;
      if (HTRANS !== 2'b00 || HADDR !== RST_ADDR) begin
         n_err++;
         $display("FAIL reset_addr_phase got %h/%h want 0/%h", HTRANS, HADDR, RST_ADDR);
      end
      n_vec++;
      if (HWRITE !== 1'b0 || HSIZE !== 3'd0 || HWDATA !== 32'h0) begin
         n_err++;
         $display("FAIL reset_ctrl got w%b s%h d%h want 0/0/0", HWRITE, HSIZE, HWDATA);
      end
      n_vec++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
         n_err++;
         $display("FAIL reset_rsp got %b/%h/%b want 0/0/0", rsp_valid, rsp_rdata, rsp_error);
      end
      n_vec++;
      if (HBURST !== 3'd0 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ties got %h/%h/%b want 0/3/0", HBURST, HPROT, HMASTLOCK);
      end
      n_vec++;
      if (cmd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready got %b want 0", cmd_ready);
      end
      HRESET = 1'b0;
      #1;
      n_vec++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_ready got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_write_read();
      int a0, a1;
      rq.delete();
      issue(32'h10, 1'b1, 2'd2, 32'hDEADBEEF, a0);
      issue(32'h10, 1'b0, 2'd2, 32'h0, a1);
      idle();
      wait_rsp(2);
      n_vec++;
      if (rq.size() != 2) begin
         n_err++;
         $display("FAIL wr_rd_count got %0d want 2", rq.size());
      end else begin
         n_vec++;
         if (rq[0].d !== 32'h0 || rq[0].e !== 1'b0 || rq[0].cyc != a0 + 3) begin
            n_err++;
            $display("FAIL wr_rsp got %h/%b@%0d want 0/0@%0d", rq[0].d, rq[0].e, rq[0].cyc, a0 + 3);
         end
         n_vec++;
         if (rq[1].d !== 32'hDEADBEEF || rq[1].e !== 1'b0 || rq[1].cyc != a0 + 5) begin
            n_err++;
            $display("FAIL rd_rsp got %h/%b@%0d want deadbeef/0@%0d", rq[1].d, rq[1].e, rq[1].cyc, a0 + 5);
         end
      end
      n_vec++;
      if (a1 != a0 + 1) begin
         n_err++;
         $display("FAIL wr_rd_b2b got accept %0d want %0d", a1, a0 + 1);
      end
   endtask

   task automatic test_byte_lanes();
      int a[5];
      logic [31:0] exp_d[5];
      logic [31:0] exp_a[5];
      logic [2:0]  exp_s[5];
      exp_d = '{32'h0, 32'hA5ADBEEF, 32'h0000A5AD, 32'hA5ADBEEF, 32'h000000BE};
      exp_a = '{32'h13, 32'h10, 32'h12, 32'h10, 32'h11};
      exp_s = '{3'd0, 3'd2, 3'd1, 3'd2, 3'd0};
      rq.delete();
      issue(32'h13, 1'b1, 2'd0, 32'h123456A5, a[0]);
      issue(32'h10, 1'b0, 2'd2, 32'h0, a[1]);
      issue(32'h13, 1'b0, 2'd1, 32'h0, a[2]);
      issue(32'h11, 1'b0, 2'd3, 32'h0, a[3]);
      issue(32'h11, 1'b0, 2'd0, 32'h0, a[4]);
      idle();
      wait_rsp(5);
      n_vec++;
      if (tr_wdata[(a[0] + 2) % 4096] !== 32'hA5A5A5A5 || tr_write[(a[0] + 1) % 4096] !== 1'b1) begin
         n_err++;
         $display("FAIL byte_hwdata got %h w%b want a5a5a5a5 w1", tr_wdata[(a[0] + 2) % 4096], tr_write[(a[0] + 1) % 4096]);
      end
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (tr_addr[(a[i] + 1) % 4096] !== exp_a[i] || tr_size[(a[i] + 1) % 4096] !== exp_s[i]) begin
            n_err++;
            $display("FAIL lane_aphase[%0d] got %h/%h want %h/%h", i, tr_addr[(a[i] + 1) % 4096], tr_size[(a[i] + 1) % 4096], exp_a[i], exp_s[i]);
         end
      end
      n_vec++;
      if (rq.size() != 5) begin
         n_err++;
         $display("FAIL lane_count got %0d want 5", rq.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (rq[i].d !== exp_d[i] || rq[i].e !== 1'b0) begin
               n_err++;
               $display("FAIL lane_rdata[%0d] got %h/%b want %h/0", i, rq[i].d, rq[i].e, exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int a[4];
      logic [31:0] exp_d[4];
      exp_d = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      rq.delete();
      for (int i = 0; i < 4; i++) issue(32'(4 * i), 1'b0, 2'd2, 32'h0, a[i]);
      idle();
      wait_rsp(4);
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (a[i] != a[0] + i || tr_trans[(a[0] + 1 + i) % 4096] !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_issue[%0d] got acc %0d trans %h want %0d/2", i, a[i], tr_trans[(a[0] + 1 + i) % 4096], a[0] + i);
         end
      end
      n_vec++;
      if (rq.size() != 4) begin
         n_err++;
         $display("FAIL b2b_count got %0d want 4", rq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rq[i].d !== exp_d[i] || rq[i].cyc != a[0] + 3 + i) begin
               n_err++;
               $display("FAIL b2b_rsp[%0d] got %h@%0d want %h@%0d", i, rq[i].d, rq[i].cyc, exp_d[i], a[0] + 3 + i);
            end
         end
      end
   endtask

   task automatic test_error();
      int a0, a1, r0, r1;
      rq.delete();
      err_req = err_req + 1;
      issue(32'h20, 1'b1, 2'd2, 32'h11112222, a0);
      issue(32'h24, 1'b1, 2'd2, 32'h33334444, a1);
      idle();
      wait_rsp(2);
      n_vec++;
      if (a1 != a0 + 1 || tr_trans[(a0 + 3) % 4096] !== 2'b00) begin
         n_err++;
         $display("FAIL err_idle got acc %0d trans %h want %0d/0", a1, tr_trans[(a0 + 3) % 4096], a0 + 1);
      end
      n_vec++;
      if (tr_ready[(a0 + 2) % 4096] !== 1'b0 || tr_ready[(a0 + 3) % 4096] !== 1'b0) begin
         n_err++;
         $display("FAIL err_ready got %b%b want 00", tr_ready[(a0 + 2) % 4096], tr_ready[(a0 + 3) % 4096]);
      end
      n_vec++;
      if (tr_trans[(a0 + 4) % 4096] !== 2'b10 || tr_addr[(a0 + 4) % 4096] !== 32'h24 ||
          tr_wdata[(a0 + 5) % 4096] !== 32'h33334444) begin
         n_err++;
         $display("FAIL err_replay got %h/%h/%h want 2/24/33334444", tr_trans[(a0 + 4) % 4096], tr_addr[(a0 + 4) % 4096], tr_wdata[(a0 + 5) % 4096]);
      end
      n_vec++;
      if (rq.size() != 2) begin
         n_err++;
         $display("FAIL err_count got %0d want 2", rq.size());
      end else begin
         n_vec++;
         if (rq[0].e !== 1'b1 || rq[0].cyc != a0 + 4) begin
            n_err++;
            $display("FAIL err_rsp0 got %b@%0d want 1@%0d", rq[0].e, rq[0].cyc, a0 + 4);
         end
         n_vec++;
         if (rq[1].e !== 1'b0 || rq[1].cyc != a0 + 6) begin
            n_err++;
            $display("FAIL err_rsp1 got %b@%0d want 0@%0d", rq[1].e, rq[1].cyc, a0 + 6);
         end
      end
      rq.delete();
      issue(32'h20, 1'b0, 2'd2, 32'h0, r0);
      issue(32'h24, 1'b0, 2'd2, 32'h0, r1);
      idle();
      wait_rsp(2);
      n_vec++;
      if (rq.size() != 2) begin
         n_err++;
         $display("FAIL err_readback_count got %0d want 2", rq.size());
      end else begin
         n_vec++;
         if (rq[0].d !== 32'h23222120 || rq[1].d !== 32'h33334444) begin
            n_err++;
            $display("FAIL err_readback got %h/%h want 23222120/33334444", rq[0].d, rq[1].d);
         end
      end
   endtask

   task automatic test_wait_states();
      int a0, a1;
      rq.delete();
      wait_len = 3;
      wait_req = wait_req + 1;
      issue(32'h04, 1'b0, 2'd2, 32'h5555AAAA, a0);
      issue(32'h08, 1'b0, 2'd2, 32'h0, a1);
      idle();
      wait_rsp(2);
      n_vec++;
      if (a1 != a0 + 1) begin
         n_err++;
         $display("FAIL ws_accept got %0d want %0d", a1, a0 + 1);
      end
      for (int c = a0 + 2; c <= a0 + 5; c++) begin
         n_vec++;
         if (tr_trans[c % 4096] !== 2'b10 || tr_addr[c % 4096] !== 32'h08 ||
             tr_wdata[c % 4096] !== 32'h5555AAAA) begin
            n_err++;
            $display("FAIL ws_frozen@%0d got %h/%h/%h want 2/8/5555aaaa", c, tr_trans[c % 4096], tr_addr[c % 4096], tr_wdata[c % 4096]);
         end
      end
      for (int c = a0 + 2; c <= a0 + 4; c++) begin
         n_vec++;
         if (tr_ready[c % 4096] !== 1'b0) begin
            n_err++;
            $display("FAIL ws_ready@%0d got %b want 0", c, tr_ready[c % 4096]);
         end
      end
      n_vec++;
      if (rq.size() != 2) begin
         n_err++;
         $display("FAIL ws_count got %0d want 2", rq.size());
      end else begin
         n_vec++;
         if (rq[0].d !== 32'h07060504 || rq[0].cyc != a0 + 6) begin
            n_err++;
            $display("FAIL ws_rsp0 got %h@%0d want 07060504@%0d", rq[0].d, rq[0].cyc, a0 + 6);
         end
         n_vec++;
         if (rq[1].d !== 32'h0B0A0908 || rq[1].cyc != a0 + 7) begin
            n_err++;
            $display("FAIL ws_rsp1 got %h@%0d want 0b0a0908@%0d", rq[1].d, rq[1].cyc, a0 + 7);
         end
      end
   endtask

   task automatic test_reset_midop();
      int a0, a1;
      rq.delete();
      issue(32'h0C, 1'b0, 2'd2, 32'h0, a0);
      idle();
      @(negedge HCLK);
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      n_vec++;
      if (HTRANS !== 2'b00 || HADDR !== RST_ADDR || rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_state got %h/%h/%b want 0/%h/0", HTRANS, HADDR, rsp_valid, RST_ADDR);
      end
      repeat (5) @(negedge HCLK);
      n_vec++;
      if (rq.size() != 0) begin
         n_err++;
         $display("FAIL midreset_dropped got %0d rsp want 0", rq.size());
      end
      rq.delete();
      issue(32'h0C, 1'b0, 2'd2, 32'h0, a1);
      idle();
      wait_rsp(1);
      n_vec++;
      if (rq.size() != 1) begin
         n_err++;
         $display("FAIL midreset_after_count got %0d want 1", rq.size());
      end else begin
         n_vec++;
         if (rq[0].d !== 32'h0F0E0D0C || rq[0].e !== 1'b0 || rq[0].cyc != a1 + 3) begin
            n_err++;
            $display("FAIL midreset_after got %h/%b@%0d want 0f0e0d0c/0@%0d", rq[0].d, rq[0].e, rq[0].cyc, a1 + 3);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_back_to_back();
      test_error();
      test_wait_states();
      test_reset_midop();
      repeat (2) @(negedge HCLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
